// File: rtl/smm_pkg.sv
// Shared widths, entry payload and controller states for the sparse matrix multiplier.
package smm_pkg;
  localparam int unsigned MAX_NNZ = 8;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned VAL_W   = 4;
  localparam int unsigned OUT_W   = 9;
  localparam int unsigned KEY_W   = 2 * IDX_W;
  localparam int unsigned PROD_W  = 2 * VAL_W;
  localparam int unsigned LIST_N  = 64;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned RD_W    = 6;
  localparam int unsigned NNZ_W   = 4;
  localparam int unsigned PTR_W   = 3;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [VAL_W-1:0] val;
  } entry_t;

  typedef enum logic [2:0] {IDLE, IN_A, IN_B, COMPUTE, OUTPUT} state_e;
endpackage

// File: rtl/smm_result_list.sv
// Sorted store of up to 64 {key, val} slots: a new key is inserted in ascending
// position, a repeated key accumulates into its existing slot.
module smm_result_list
  import smm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             ins_valid_i,
  input  logic [KEY_W-1:0] ins_key_i,
  input  logic [OUT_W-1:0] ins_val_i,
  input  logic [RD_W-1:0]  rd_idx_i,
  output logic [KEY_W-1:0] rd_key_c_o,
  output logic [OUT_W-1:0] rd_val_c_o,
  output logic [CNT_W-1:0] count_o
);
  logic [KEY_W-1:0] key_q [LIST_N];
  logic [OUT_W-1:0] val_q [LIST_N];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] pos_c;
  logic             hit_c;
  logic [RD_W-1:0]  hit_idx_c;

  // Insert position = number of live keys smaller than the new one.
  always_comb begin
    pos_c     = '0;
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int s = 0; s < LIST_N; s++) begin
      if (CNT_W'(s) < count_q) begin
        if (key_q[s] < ins_key_i) pos_c = pos_c + CNT_W'(1);
        if (key_q[s] == ins_key_i) begin
          hit_c     = 1'b1;
          hit_idx_c = RD_W'(s);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int s = 0; s < LIST_N; s++) begin
        key_q[s] <= '0;
        val_q[s] <= '0;
      end
    end else if (clr_i) begin
      count_q <= '0;
    end else if (ins_valid_i) begin
      if (hit_c) begin
        val_q[hit_idx_c] <= val_q[hit_idx_c] + ins_val_i;
      end else if (count_q < CNT_W'(LIST_N)) begin
        for (int s = 1; s < LIST_N; s++) begin
          if (CNT_W'(s) > pos_c) begin
            key_q[s] <= key_q[s-1];
            val_q[s] <= val_q[s-1];
          end
        end
        key_q[pos_c[RD_W-1:0]] <= ins_key_i;
        val_q[pos_c[RD_W-1:0]] <= ins_val_i;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign rd_key_c_o = key_q[rd_idx_i];
  assign rd_val_c_o = val_q[rd_idx_i];
  assign count_o    = count_q;
endmodule

// File: rtl/sparse_matrix_mult.sv
// Sparse C = A x B over coordinate lists; walks every A/B pair once and streams
// the sorted non-zero entries of C out one per cycle.
module sparse_matrix_mult
  import smm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_size,
  input  logic             in_size,
  input  logic             in_valid_a,
  input  logic [IDX_W-1:0] in_row_a,
  input  logic [IDX_W-1:0] in_col_a,
  input  logic [VAL_W-1:0] in_val_a,
  input  logic             in_valid_b,
  input  logic [IDX_W-1:0] in_row_b,
  input  logic [IDX_W-1:0] in_col_b,
  input  logic [VAL_W-1:0] in_val_b,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic [OUT_W-1:0] out_val
);
  state_e           state_q, state_d;
  logic             size_q, size_d;
  logic [NNZ_W-1:0] na_q, na_d, nb_q, nb_d;
  logic [PTR_W-1:0] i_q, i_d, j_q, j_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [OUT_W-1:0] out_val_q, out_val_d;
  entry_t           a_q [MAX_NNZ];
  entry_t           b_q [MAX_NNZ];

  logic             a_we_c, b_we_c, clr_c, ins_valid_c, last_i_c, last_j_c;
  logic [IDX_W-1:0] mask_c;
  entry_t           in_a_c, in_b_c, pa_c, pb_c;
  logic [PROD_W-1:0] prod_c;
  logic [KEY_W-1:0] rd_key_c;
  logic [OUT_W-1:0] rd_val_c;
  logic [CNT_W-1:0] count;

  // 16x16 jobs ignore the top index bit.
  assign mask_c   = {size_q, {(IDX_W-1){1'b1}}};
  assign in_a_c   = '{row: in_row_a & mask_c, col: in_col_a & mask_c, val: in_val_a};
  assign in_b_c   = '{row: in_row_b & mask_c, col: in_col_b & mask_c, val: in_val_b};
  assign pa_c     = a_q[i_q];
  assign pb_c     = b_q[j_q];
  assign prod_c   = PROD_W'(pa_c.val) * PROD_W'(pb_c.val);
  assign last_i_c = {1'b0, i_q} == na_q - NNZ_W'(1);
  assign last_j_c = {1'b0, j_q} == nb_q - NNZ_W'(1);

  smm_result_list u_list (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .clr_i       (clr_c),
    .ins_valid_i (ins_valid_c),
    .ins_key_i   ({pa_c.row, pb_c.col}),
    .ins_val_i   (OUT_W'(prod_c)),
    .rd_idx_i    (rd_q),
    .rd_key_c_o  (rd_key_c),
    .rd_val_c_o  (rd_val_c),
    .count_o     (count)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    na_d        = na_q;
    nb_d        = nb_q;
    i_d         = i_q;
    j_d         = j_q;
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    out_row_d   = '0;
    out_col_d   = '0;
    out_val_d   = '0;
    a_we_c      = 1'b0;
    b_we_c      = 1'b0;
    clr_c       = 1'b0;
    ins_valid_c = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid_size) begin
        state_d = IN_A;
        size_d  = in_size;
        na_d    = '0;
        nb_d    = '0;
        clr_c   = 1'b1;
      end
      IN_A: begin
        if (in_valid_b) begin
          state_d = IN_B;
          b_we_c  = nb_q < NNZ_W'(MAX_NNZ);
        end else if (in_valid_a) begin
          a_we_c  = na_q < NNZ_W'(MAX_NNZ);
        end
      end
      IN_B: begin
        if (in_valid_b) begin
          b_we_c = nb_q < NNZ_W'(MAX_NNZ);
        end else begin
          state_d = (na_q == '0 || nb_q == '0) ? OUTPUT : COMPUTE;
          i_d     = '0;
          j_d     = '0;
          rd_d    = '0;
        end
      end
      COMPUTE: begin
        ins_valid_c = pa_c.col == pb_c.row;
        if (last_i_c && last_j_c) begin
          state_d = OUTPUT;
        end else if (last_j_c) begin
          j_d = '0;
          i_d = i_q + PTR_W'(1);
        end else begin
          j_d = j_q + PTR_W'(1);
        end
      end
      OUTPUT: begin
        out_valid_d = 1'b1;
        if (count == '0) begin
          state_d = IDLE;
        end else begin
          out_row_d = rd_key_c[KEY_W-1 -: IDX_W];
          out_col_d = rd_key_c[IDX_W-1:0];
          out_val_d = rd_val_c;
          if (CNT_W'(rd_q) == count - CNT_W'(1)) state_d = IDLE;
          else rd_d = rd_q + RD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (a_we_c) na_d = na_q + NNZ_W'(1);
    if (b_we_c) nb_d = nb_q + NNZ_W'(1);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      size_q      <= 1'b0;
      na_q        <= '0;
      nb_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_val_q   <= '0;
      for (int k = 0; k < MAX_NNZ; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      na_q        <= na_d;
      nb_q        <= nb_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_val_q   <= out_val_d;
      if (a_we_c) a_q[na_q[PTR_W-1:0]] <= in_a_c;
      if (b_we_c) b_q[nb_q[PTR_W-1:0]] <= in_b_c;
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_val   = out_val_q;
endmodule

// File: tb/tb_sparse_matrix_mult.sv
// Directed and random jobs checked against a dense-matrix reference model.
module tb_sparse_matrix_mult;
  import smm_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid_size, in_size, in_valid_a, in_valid_b;
  logic [IDX_W-1:0] in_row_a, in_col_a, in_row_b, in_col_b;
  logic [VAL_W-1:0] in_val_a, in_val_b;
  logic             out_valid;
  logic [IDX_W-1:0] out_row, out_col;
  logic [OUT_W-1:0] out_val;

  int n_vec = 0;
  int n_err = 0;
  int jsize, jna, jnb, max_sum;
  int ja_r[8], ja_c[8], ja_v[8], jb_r[8], jb_c[8], jb_v[8];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sparse_matrix_mult dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_size(in_valid_size), .in_size(in_size),
    .in_valid_a(in_valid_a), .in_row_a(in_row_a), .in_col_a(in_col_a), .in_val_a(in_val_a),
    .in_valid_b(in_valid_b), .in_row_b(in_row_b), .in_col_b(in_col_b), .in_val_b(in_val_b),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_val(out_val)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Dense C accumulated from every matching pair, scanned row-major.
  function automatic void build_model();
    int sum [32][32];
    bit hit [32][32];
    int dim;
    dim = (jsize != 0) ? 32 : 16;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        sum[r][c] = 0;
        hit[r][c] = 1'b0;
      end
    for (int i = 0; i < jna; i++)
      for (int j = 0; j < jnb; j++)
        if (ja_c[i] == jb_r[j]) begin
          hit[ja_r[i]][jb_c[j]] = 1'b1;
          sum[ja_r[i]][jb_c[j]] += ja_v[i] * jb_v[j];
        end
    exp_q.delete();
    max_sum = 0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        if (hit[r][c]) begin
          exp_q.push_back(32'((r << 14) | (c << 9) | (sum[r][c] % 512)));
          if (sum[r][c] > max_sum) max_sum = sum[r][c];
        end
    if (exp_q.size() == 0) exp_q.push_back(32'd0);
  endfunction

  task automatic send_inputs();
    in_valid_size = 1'b1;
    in_size = jsize[0];
    step();
    in_valid_size = 1'b0;
    for (int i = 0; i < jna; i++) begin
      in_valid_a = 1'b1;
      in_row_a = IDX_W'(ja_r[i]);
      in_col_a = IDX_W'(ja_c[i]);
      in_val_a = VAL_W'(ja_v[i]);
      step();
    end
    in_valid_a = 1'b0;
    for (int j = 0; j < jnb; j++) begin
      in_valid_b = 1'b1;
      in_row_b = IDX_W'(jb_r[j]);
      in_col_b = IDX_W'(jb_c[j]);
      in_val_b = VAL_W'(jb_v[j]);
      step();
    end
    in_valid_b = 1'b0;
  endtask

  task automatic run_job(input string tag);
    int lat;
    int k;
    build_model();
    send_inputs();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(out_valid), 32'd1);
    if (out_valid !== 1'b1) return;
    k = 0;
    while (out_valid === 1'b1 && k < 100) begin
      chk({tag, " entry"}, {13'd0, out_row, out_col, out_val},
          (k < exp_q.size()) ? exp_q[k] : 32'hffff_ffff);
      k++;
      step();
    end
    chk({tag, " count"}, 32'(k), 32'(exp_q.size()));
    chk({tag, " idle zero"}, {13'd0, out_row, out_col, out_val}, 32'd0);
  endtask

  task automatic gen_random();
    int dim, rng;
    bit dup;
    do begin
      jsize = int'($urandom_range(0, 1));
      dim = (jsize != 0) ? 32 : 16;
      rng = ($urandom_range(0, 2) == 0) ? dim - 1 : 3;
      jna = 8;
      jnb = 8;
      for (int a = 0; a < 8; a++) begin
        do begin
          ja_r[a] = int'($urandom_range(0, rng));
          ja_c[a] = int'($urandom_range(0, rng));
          dup = 1'b0;
          for (int p = 0; p < a; p++) if (ja_r[p] == ja_r[a] && ja_c[p] == ja_c[a]) dup = 1'b1;
        end while (dup);
        ja_v[a] = int'($urandom_range(1, 15));
      end
      for (int b = 0; b < 8; b++) begin
        do begin
          jb_r[b] = int'($urandom_range(0, rng));
          jb_c[b] = int'($urandom_range(0, rng));
          dup = 1'b0;
          for (int p = 0; p < b; p++) if (jb_r[p] == jb_r[b] && jb_c[p] == jb_c[b]) dup = 1'b1;
        end while (dup);
        jb_v[b] = int'($urandom_range(1, 15));
      end
      build_model();
    end while (max_sum > 511);
  endtask

  initial begin
    int bad_v, bad_d;
    rst_n = 1'b1;
    in_valid_size = 1'b0; in_size = 1'b0;
    in_valid_a = 1'b0; in_row_a = '0; in_col_a = '0; in_val_a = '0;
    in_valid_b = 1'b0; in_row_b = '0; in_col_b = '0; in_val_b = '0;
    step();
    step();
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset data", {13'd0, out_row, out_col, out_val}, 32'd0);
    rst_n = 1'b0;
    step();

    jsize = 0; jna = 1; jnb = 1;
    ja_r[0] = 0; ja_c[0] = 0; ja_v[0] = 3;
    jb_r[0] = 0; jb_c[0] = 1; jb_v[0] = 5;
    run_job("single");

    jsize = 1; jna = 2; jnb = 2;
    ja_r[0] = 31; ja_c[0] = 2; ja_v[0] = 15; ja_r[1] = 31; ja_c[1] = 3; ja_v[1] = 15;
    jb_r[0] = 2; jb_c[0] = 31; jb_v[0] = 15; jb_r[1] = 3; jb_c[1] = 31; jb_v[1] = 15;
    run_job("accum450");

    jsize = 0; jna = 1; jnb = 1;
    ja_r[0] = 1; ja_c[0] = 4; ja_v[0] = 2;
    jb_r[0] = 5; jb_c[0] = 0; jb_v[0] = 7;
    run_job("empty");

    jsize = 0; jna = 2; jnb = 2;
    ja_r[0] = 3; ja_c[0] = 1; ja_v[0] = 1; ja_r[1] = 0; ja_c[1] = 1; ja_v[1] = 1;
    jb_r[0] = 1; jb_c[0] = 9; jb_v[0] = 2; jb_r[1] = 1; jb_c[1] = 2; jb_v[1] = 4;
    run_job("sorted4");

    // Abort during the B burst: nothing may come out afterwards.
    in_valid_size = 1'b1; in_size = 1'b0;
    step();
    in_valid_size = 1'b0;
    in_valid_a = 1'b1; in_row_a = 5'd2; in_col_a = 5'd3; in_val_a = 4'd6;
    step();
    in_valid_a = 1'b0;
    in_valid_b = 1'b1; in_row_b = 5'd3; in_col_b = 5'd4; in_val_b = 4'd7;
    step();
    rst_n = 1'b1;
    step();
    in_valid_b = 1'b0;
    rst_n = 1'b0;
    bad_v = 0;
    bad_d = 0;
    for (int t = 0; t < 120; t++) begin
      if (out_valid !== 1'b0) bad_v++;
      if ({out_row, out_col, out_val} !== '0) bad_d++;
      step();
    end
    chk("abort valid", 32'(bad_v), 32'd0);
    chk("abort data", 32'(bad_d), 32'd0);
    jsize = 0; jna = 1; jnb = 1;
    ja_r[0] = 7; ja_c[0] = 5; ja_v[0] = 9;
    jb_r[0] = 5; jb_c[0] = 12; jb_v[0] = 11;
    run_job("post-abort");

    for (int n = 0; n < 400; n++) begin
      gen_random();
      run_job("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
